// File: rtl/core_pkg.sv
// Shared pipeline definitions for the RV32I core: widths, encodings, control bundles.
package core_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned RADDR_W   = 5;
    localparam int unsigned ALUCTRL_W = 3;
    localparam int unsigned RESSRC_W  = 2;

    // Source selected for the write-back result.
    typedef enum logic [RESSRC_W-1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Decode control bundle carried through ID/EX, plus the stage valid bit.
    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        result_src_e          result_src;
        logic                 mem_write;
        logic                 jump;
        logic                 branch;
        logic [ALUCTRL_W-1:0] alu_control;
        logic                 alu_src;
    } id_ex_ctrl_t;

    // All-zero bubble: no write, no memory access, no redirect, not valid.
    localparam id_ex_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/pipe_flop_enclr.sv
// Pipeline flop group: async reset, synchronous clear (wins) and load enable.
module pipe_flop_enclr #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear beats enable so a flush always inserts a bubble, even while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall/flush, PC-redirect resolution and a bubble counter.
module id_ex_stage_reg
    import core_pkg::*;
#(
    parameter int unsigned XLEN    = core_pkg::XLEN,
    parameter int unsigned RADDR_W = core_pkg::RADDR_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 RegWriteD,
    input  logic [RESSRC_W-1:0]  ResultSrcD,
    input  logic                 MemWriteD,
    input  logic                 JumpD,
    input  logic                 BranchD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic                 ALUSrcD,
    input  logic [XLEN-1:0]      RD1D,
    input  logic [XLEN-1:0]      RD2D,
    input  logic [XLEN-1:0]      PCD,
    input  logic [XLEN-1:0]      PCPlus4D,
    input  logic [XLEN-1:0]      ImmExtD,
    input  logic [RADDR_W-1:0]   Rs1D,
    input  logic [RADDR_W-1:0]   Rs2D,
    input  logic [RADDR_W-1:0]   RdD,
    input  logic                 ZeroE,
    output logic                 RegWriteE,
    output logic [RESSRC_W-1:0]  ResultSrcE,
    output logic                 MemWriteE,
    output logic                 JumpE,
    output logic                 BranchE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic [XLEN-1:0]      RD1E,
    output logic [XLEN-1:0]      RD2E,
    output logic [XLEN-1:0]      PCE,
    output logic [XLEN-1:0]      PCPlus4E,
    output logic [XLEN-1:0]      ImmExtE,
    output logic [RADDR_W-1:0]   Rs1E,
    output logic [RADDR_W-1:0]   Rs2E,
    output logic [RADDR_W-1:0]   RdE,
    output logic                 ValidE,
    output logic                 PCSrcE,
    output logic [CNT_W-1:0]     BubbleCntE
);

    localparam int unsigned CTRL_W = $bits(id_ex_ctrl_t);
    localparam int unsigned DATA_W = 5 * XLEN;
    localparam int unsigned ADDR_W = 3 * RADDR_W;

    id_ex_ctrl_t       ctrl_d;
    id_ex_ctrl_t       ctrl_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_q;
    logic              load_en;

    assign load_en = ~StallE;

    // Pack decode-stage fields into their flop groups.
    always_comb begin
        ctrl_d             = BUBBLE;
        ctrl_d.valid       = 1'b1;
        ctrl_d.reg_write   = RegWriteD;
        ctrl_d.result_src  = result_src_e'(ResultSrcD);
        ctrl_d.mem_write   = MemWriteD;
        ctrl_d.jump        = JumpD;
        ctrl_d.branch      = BranchD;
        ctrl_d.alu_control = ALUControlD;
        ctrl_d.alu_src     = ALUSrcD;
        data_d             = {RD1D, RD2D, PCD, PCPlus4D, ImmExtD};
        addr_d             = {Rs1D, Rs2D, RdD};
    end

    pipe_flop_enclr #(.W(CTRL_W)) u_ctrl_flop (
        .clk (clk),
        .rst (rst),
        .en  (load_en),
        .clr (FlushE),
        .d   (ctrl_d),
        .q   (ctrl_q)
    );

    pipe_flop_enclr #(.W(DATA_W)) u_data_flop (
        .clk (clk),
        .rst (rst),
        .en  (load_en),
        .clr (FlushE),
        .d   (data_d),
        .q   (data_q)
    );

    pipe_flop_enclr #(.W(ADDR_W)) u_addr_flop (
        .clk (clk),
        .rst (rst),
        .en  (load_en),
        .clr (FlushE),
        .d   (addr_d),
        .q   (addr_q)
    );

    // Unpack E-stage registers onto the output ports.
    always_comb begin
        ValidE      = ctrl_q.valid;
        RegWriteE   = ctrl_q.reg_write;
        ResultSrcE  = ctrl_q.result_src;
        MemWriteE   = ctrl_q.mem_write;
        JumpE       = ctrl_q.jump;
        BranchE     = ctrl_q.branch;
        ALUControlE = ctrl_q.alu_control;
        ALUSrcE     = ctrl_q.alu_src;
        {RD1E, RD2E, PCE, PCPlus4E, ImmExtE} = data_q;
        {Rs1E, Rs2E, RdE}                    = addr_q;
    end

    // Redirect only for a real instruction; a bubble has valid/jump/branch all clear.
    assign PCSrcE = ctrl_q.valid & ((ctrl_q.branch & ZeroE) | ctrl_q.jump);

    // Saturating count of flush edges, for performance debug.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BubbleCntE <= '0;
        end else if (FlushE && (BubbleCntE != {CNT_W{1'b1}})) begin
            BubbleCntE <= BubbleCntE + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for the ID/EX pipeline register.
module tb_id_ex_stage_reg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               StallE, FlushE;
    logic               RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]         ResultSrcD;
    logic [2:0]         ALUControlD;
    logic [XLEN-1:0]    RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [RADDR_W-1:0] Rs1D, Rs2D, RdD;
    logic               ZeroE;
    logic               RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]         ResultSrcE;
    logic [2:0]         ALUControlE;
    logic [XLEN-1:0]    RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [RADDR_W-1:0] Rs1E, Rs2E, RdE;
    logic               ValidE, PCSrcE;
    logic [CNT_W-1:0]   BubbleCntE;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ValidE(ValidE), .PCSrcE(PCSrcE), .BubbleCntE(BubbleCntE)
    );

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive the decode-stage inputs; PC+4 follows PC.
    task automatic drive_d(input logic rw, input logic [1:0] rs, input logic mw,
                           input logic j, input logic b, input logic [2:0] alu,
                           input logic src, input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        RegWriteD = rw; ResultSrcD = rs; MemWriteD = mw; JumpD = j; BranchD = b;
        ALUControlD = alu; ALUSrcD = src; RD1D = rd1; RD2D = rd2; PCD = pc;
        PCPlus4D = pc + 32'd4; ImmExtD = imm; Rs1D = r1; Rs2D = r2; RdD = rd;
    endtask

    initial begin
        rst = 1'b1; StallE = 1'b0; FlushE = 1'b0; ZeroE = 1'b0;
        drive_d(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        check("reset_valid", ValidE, 1'b0);
        check("reset_cnt", BubbleCntE, 4'h0);
        rst = 1'b0;

        // Load: jump instruction so PCSrcE is observable before the mid-cycle reset.
        drive_d(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 32'h0000_0005, 32'h0000_0009,
                32'h0000_0100, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd7);
        @(negedge clk);
        check("load_regwrite", RegWriteE, 1'b1);
        check("load_aluctrl", ALUControlE, 3'b010);
        check("load_rd1", RD1E, 32'h5);
        check("load_rd", RdE, 5'd7);
        check("load_valid", ValidE, 1'b1);
        check("load_pcplus4", PCPlus4E, 32'h104);
        check("load_resultsrc", ResultSrcE, 2'b10);
        check("load_pcsrc", PCSrcE, 1'b1);

        // Mid-cycle async reset clears outputs before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", ValidE, 1'b0);
        check("async_rst_regwrite", RegWriteE, 1'b0);
        check("async_rst_rd1", RD1E, 32'h0);
        check("async_rst_rd", RdE, 5'd0);
        check("async_rst_pcsrc", PCSrcE, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", ValidE, 1'b1);
        check("post_rst_rd1", RD1E, 32'h5);

        // Stall for three edges while D changes underneath.
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_d(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 32'hA0 + 32'(i), 32'hB0,
                    32'h200, 32'h4, 5'd3, 5'd4, 5'd9 + 5'(i));
            @(negedge clk);
            check("stall_rd1", RD1E, 32'h5);
            check("stall_rd", RdE, 5'd7);
            check("stall_valid", ValidE, 1'b1);
            check("stall_cnt", BubbleCntE, 4'h0);
        end
        StallE = 1'b0;
        @(negedge clk);
        check("unstall_rd1", RD1E, 32'hA2);
        check("unstall_rd", RdE, 5'd11);
        check("unstall_memwrite", MemWriteE, 1'b1);

        // Flush wins over stall.
        StallE = 1'b1; FlushE = 1'b1; ZeroE = 1'b1;
        drive_d(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 32'h11, 32'h22, 32'h300, 32'h8, 5'd5, 5'd6, 5'd8);
        @(negedge clk);
        check("flush_branch", BranchE, 1'b0);
        check("flush_valid", ValidE, 1'b0);
        check("flush_rd", RdE, 5'd0);
        check("flush_rd1", RD1E, 32'h0);
        check("flush_cnt", BubbleCntE, 4'h1);
        check("flush_pcsrc", PCSrcE, 1'b0);

        // Branch redirect depends on ZeroE combinationally.
        StallE = 1'b0; FlushE = 1'b0;
        @(negedge clk);
        check("branch_zero1", PCSrcE, 1'b1);
        ZeroE = 1'b0;
        #1;
        check("branch_zero0", PCSrcE, 1'b0);
        drive_d(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h400, 32'h10, 5'd0, 5'd0, 5'd1);
        @(negedge clk);
        check("jump_zero0", PCSrcE, 1'b1);
        ZeroE = 1'b1;
        #1;
        check("jump_zero1", PCSrcE, 1'b1);
        check("cnt_after_loads", BubbleCntE, 4'h1);

        // Saturation: 20 consecutive flushes on top of the one already counted.
        FlushE = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 4) check("sat_mid_cnt", BubbleCntE, 4'h6);
        end
        check("sat_cnt", BubbleCntE, 4'hF);
        FlushE = 1'b0;
        @(negedge clk);
        check("sat_hold_cnt", BubbleCntE, 4'hF);
        check("sat_load_valid", ValidE, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
